// File: rtl/auth_msg_serializer_pkg.sv
// Shared auth definitions: message width, byte-count constant and serializer state encodings.
`ifndef MSG_LEN
`define MSG_LEN 64
`endif

package auth_msg_serializer_pkg;

    localparam int AUTH_MSG_LEN = `MSG_LEN;

    function automatic logic [15:0] msg_bytes(input int len_bits);
        return 16'(len_bits / 8);
    endfunction

    localparam logic [15:0] AUTH_MSG_BYTES = msg_bytes(AUTH_MSG_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } auth_state_e;

endpackage

// File: rtl/auth_msg_serializer_tx_stall_timer.sv
// Counts consecutive stalled cycles.
// The counter saturates at TIMEOUT_CYCLES, so it cannot wrap before the abort.
module tx_stall_timer #(
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    // Expiry flags the stall edge that would bring the count to TIMEOUT_CYCLES.
    assign expired_o = enable_i && (count_q >= LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q < TOP)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/auth_msg_serializer.sv
// Serializes a parallel authentication message MSB byte first over a valid/ready byte link.
// The driver is acknowledged on completion or on a stall abort.
module auth_msg_serializer
    import auth_msg_serializer_pkg::*;
#(
    parameter int MSG_LEN        = AUTH_MSG_LEN,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MSG_LEN-1:0] auth_msg_in,
    input  logic               auth_msg_ready,
    input  logic [15:0]        msg_len_bytes,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               tx_last,
    output logic               Ack_out,
    output logic               tx_error,
    output logic               busy
);

    localparam logic [15:0] MSG_BYTES =
        (MSG_LEN == AUTH_MSG_LEN) ? AUTH_MSG_BYTES : msg_bytes(MSG_LEN);

    auth_state_e        state_q;
    logic [MSG_LEN-1:0] shreg_q;
    logic [15:0]        cnt_q;
    logic               err_q;
    logic               tx_valid_q, tx_last_q, ack_q, tx_error_q, busy_q;

    logic [15:0] load_cnt;
    logic        stall_en, stall_clr, stall_expired;

    assign load_cnt  = (msg_len_bytes > MSG_BYTES) ? MSG_BYTES : msg_len_bytes;
    assign stall_en  = (state_q == ST_SEND) && tx_valid_q && !tx_ready;
    assign stall_clr = (state_q != ST_SEND) || (tx_valid_q && tx_ready);

    tx_stall_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk      (clk),
        .reset    (reset),
        .enable_i (stall_en),
        .clear_i  (stall_clr),
        .expired_o(stall_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            ack_q      <= 1'b0;
            tx_error_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack_q      <= 1'b0;
            tx_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (auth_msg_ready) begin
                        shreg_q <= auth_msg_in;
                        cnt_q   <= load_cnt;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (load_cnt == 16'd0) begin
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_SEND;
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= (load_cnt == 16'd1);
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        shreg_q <= shreg_q << 8;
                        cnt_q   <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            ack_q      <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            tx_last_q <= (cnt_q == 16'd2);
                        end
                    end else if (stall_expired) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        cnt_q      <= '0;
                        err_q      <= 1'b1;
                        ack_q      <= 1'b1;
                        tx_error_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                // Ack/tx_error are raised on entry so they are high for exactly the DONE cycle.
                ST_DONE: begin
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!auth_msg_ready) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_byte  = shreg_q[MSG_LEN-1 -: 8];
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign Ack_out  = ack_q;
    assign tx_error = tx_error_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_auth_msg_serializer.sv
// Directed bench for auth_msg_serializer: MSG_LEN=64, TIMEOUT_CYCLES=4.
module tb_auth_msg_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] auth_msg_in;
    logic        auth_msg_ready;
    logic [15:0] msg_len_bytes;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        Ack_out;
    logic        tx_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    auth_msg_serializer #(
        .MSG_LEN       (64),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .auth_msg_in   (auth_msg_in),
        .auth_msg_ready(auth_msg_ready),
        .msg_len_bytes (msg_len_bytes),
        .tx_byte       (tx_byte),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_last       (tx_last),
        .Ack_out       (Ack_out),
        .tx_error      (tx_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Checks the visible link state for one cycle.
    task automatic chk_link(input string tag, input logic [7:0] b, input logic v,
                            input logic l, input logic a, input logic e);
        if (v) chk({tag, ".byte"}, 64'(tx_byte), 64'(b));
        chk({tag, ".valid"}, 64'(tx_valid), 64'(v));
        chk({tag, ".last"},  64'(tx_last),  64'(l));
        chk({tag, ".ack"},   64'(Ack_out),  64'(a));
        chk({tag, ".err"},   64'(tx_error), 64'(e));
    endtask

    initial begin
        reset          = 1'b1;
        auth_msg_in    = 64'h0102_0304_0506_0708;
        auth_msg_ready = 1'b0;
        msg_len_bytes  = 16'd0;
        tx_ready       = 1'b0;
        step();
        step();
        chk("rst.byte", 64'(tx_byte), 64'h0);
        chk_link("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.busy", 64'(busy), 64'h0);
        reset = 1'b0;
        step();
        chk("idle.busy", 64'(busy), 64'h0);

        // Full 8-byte message, link always ready: one byte per cycle.
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd8;
        tx_ready       = 1'b1;
        step();
        auth_msg_ready = 1'b0;
        chk("full.busy", 64'(busy), 64'h1);
        for (int i = 1; i <= 8; i++) begin
            chk_link("full", 8'(i), 1'b1, (i == 8), 1'b0, 1'b0);
            step();
        end
        chk_link("full.end", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk_link("full.hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full.hold.busy", 64'(busy), 64'h1);
        step();
        chk("full.idle.busy", 64'(busy), 64'h0);

        // Three bytes with tx_ready toggling 1,0,1,0,1.
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd3;
        step();
        auth_msg_ready = 1'b0;
        auth_msg_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        tx_ready = 1'b1;
        chk_link("tgl.b1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        tx_ready = 1'b0;
        chk_link("tgl.b2", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_link("tgl.b2s", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk_link("tgl.b3", 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_link("tgl.b3s", 8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        tx_ready = 1'b1;
        step();
        chk_link("tgl.end", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("tgl.idle.busy", 64'(busy), 64'h0);

        // Zero-length message: acknowledged in the cycle after capture, nothing sent.
        auth_msg_in    = 64'h0102_0304_0506_0708;
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd0;
        step();
        auth_msg_ready = 1'b0;
        chk_link("zero.ack", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("zero.busy", 64'(busy), 64'h1);
        step();
        chk_link("zero.after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("zero.idle.busy", 64'(busy), 64'h0);

        // Oversized length clamps to 8 bytes.
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd20;
        step();
        auth_msg_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk_link("clamp", 8'(i), 1'b1, (i == 8), 1'b0, 1'b0);
            step();
        end
        chk_link("clamp.end", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        chk("clamp.idle.busy", 64'(busy), 64'h0);

        // Stall timeout: 4 stalled cycles then abort with Ack and tx_error together.
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd8;
        tx_ready       = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_link("tmo.stall", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk_link("tmo.abort", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk_link("tmo.after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // auth_msg_ready still high: the held message must not be resent.
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_link("hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("hold.busy", 64'(busy), 64'h1);
            step();
        end
        auth_msg_ready = 1'b0;
        step();
        chk("hold.idle.busy", 64'(busy), 64'h0);
        chk("hold.idle.valid", 64'(tx_valid), 64'h0);

        // Reset after the 2nd byte transfers: message abandoned with no Ack.
        auth_msg_ready = 1'b1;
        msg_len_bytes  = 16'd8;
        tx_ready       = 1'b1;
        step();
        chk_link("rmid.b1", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_link("rmid.b2", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_link("rmid.b3", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid.byte", 64'(tx_byte), 64'h0);
        chk_link("rmid.rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rmid.busy", 64'(busy), 64'h0);
        step();
        auth_msg_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk_link("rmid.new", 8'(i), 1'b1, (i == 8), 1'b0, 1'b0);
            step();
        end
        chk_link("rmid.end", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
